// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared types and helpers for the n_bit_comparator tree.
//   CMP_GT / CMP_LT / CMP_EQ : one-hot encodings, bit order {great, less, equal}
//   cmp_pair_t               : (gt, lt) partial result for a span of bits
//   cmp_merge(hi, lo)        : combine a more-significant span with a less
//                              significant one
// ---------------------------------------------------------------------------
package cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  typedef struct packed {
    logic gt;
    logic lt;
  } cmp_pair_t;

  // The more significant span decides as soon as it differs; only when it is
  // equal (both flags clear) does the less significant span matter.
  function automatic cmp_pair_t cmp_merge(cmp_pair_t hi, cmp_pair_t lo);
    return (hi.gt | hi.lt) ? hi : lo;
  endfunction

endpackage

// File: rtl/cmp_merge_cell.sv
// ---------------------------------------------------------------------------
// cmp_merge_cell
// One combinational node of the comparator tree.
//   hi_i  : (gt, lt) pair of the more significant span
//   lo_i  : (gt, lt) pair of the less significant span
//   out_o : merged pair covering both spans
// ---------------------------------------------------------------------------
module cmp_merge_cell
  import cmp_pkg::*;
(
  input  cmp_pair_t hi_i,
  input  cmp_pair_t lo_i,
  output cmp_pair_t out_o
);

  assign out_o = cmp_merge(hi_i, lo_i);

endmodule

// File: rtl/n_bit_comparator.sv
// ---------------------------------------------------------------------------
// n_bit_comparator
// Registered magnitude comparator for two N-bit operands (N = 1..64).
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   in_valid  : x / y are valid this cycle
//   x, y      : operands
//   great     : registered x > y
//   less      : registered x < y
//   equal     : registered x == y
//   out_valid : great/less/equal hold a fresh result
// Handshake: valid-only, no ready. A pair presented with in_valid=1 on edge k
// yields its flags with out_valid=1 after edge k; there is no backpressure.
// When in_valid=0 the flags keep their last value and out_valid drops.
// Build option: define NBITCMP_SIGNED_EN for two's complement operands
// (default build compares unsigned).
// ---------------------------------------------------------------------------
module n_bit_comparator
  import cmp_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         great,
  output logic         less,
  output logic         equal,
  output logic         out_valid
);

  // Tree geometry: leaves padded up to a power of two.
  localparam int LG = (N > 1) ? $clog2(N) : 0;
  localparam int P  = 1 << LG;

  logic [N-1:0] xa, ya;

  // Flipping both sign bits maps two's complement order onto unsigned order,
  // so the tree itself never needs to know about signedness.
  always_comb begin
    xa = x;
    ya = y;
`ifdef NBITCMP_SIGNED_EN
    xa[N-1] = ~x[N-1];
    ya[N-1] = ~y[N-1];
`endif
  end

  // Level 0 holds the leaves in MSB-first order (index 0 = bit N-1); padding
  // leaves sit at the LSB end and are (0,0). Level l has P>>l nodes.
  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    cmp_pair_t p [P >> l];

    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < P; k++) begin : g_k
        if (k < N) begin : g_real
          assign p[k] = {xa[N-1-k] & ~ya[N-1-k], ~xa[N-1-k] & ya[N-1-k]};
        end else begin : g_pad
          assign p[k] = '0;
        end
      end
    end else begin : g_merge
      for (genvar j = 0; j < (P >> l); j++) begin : g_j
        // A right (less significant) child made only of padding is always
        // (0,0), so the left child passes straight through. This leaves
        // exactly N-1 real merge cells.
        if ((2 * j + 1) * (1 << (l - 1)) < N) begin : g_cell
          cmp_merge_cell u_cell (
            .hi_i  (g_lvl[l-1].p[2*j]),
            .lo_i  (g_lvl[l-1].p[2*j+1]),
            .out_o (p[j])
          );
        end else begin : g_pass
          assign p[j] = g_lvl[l-1].p[2*j];
        end
      end
    end
  end

  cmp_pair_t  root;
  logic [2:0] flags_d, flags_q;
  logic       valid_q;

  assign root = g_lvl[LG].p[0];

  // Ordering {great, less, equal}, matching CMP_GT / CMP_LT / CMP_EQ.
  assign flags_d = {root.gt, root.lt, ~(root.gt | root.lt)};

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        flags_q <= flags_d;
      end
    end
  end

  assign great     = flags_q[2];
  assign less      = flags_q[1];
  assign equal     = flags_q[0];
  assign out_valid = valid_q;

  a_onehot : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> $onehot({great, less, equal}));

endmodule

// File: tb/tb_n_bit_comparator.sv
module tb_n_bit_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;

  logic [3:0] x4 = '0, y4 = '0;
  logic [0:0] x1 = '0, y1 = '0;
  logic [4:0] x5 = '0, y5 = '0;
  logic [7:0] x8 = '0, y8 = '0;
  logic g4, l4, e4, v4;
  logic g1, l1, e1, v1;
  logic g5, l5, e5, v5;
  logic g8, l8, e8, v8;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  n_bit_comparator #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x4), .y(y4),
    .great(g4), .less(l4), .equal(e4), .out_valid(v4));
  n_bit_comparator #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x1), .y(y1),
    .great(g1), .less(l1), .equal(e1), .out_valid(v1));
  n_bit_comparator #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x5), .y(y5),
    .great(g5), .less(l5), .equal(e5), .out_valid(v5));
  n_bit_comparator #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x8), .y(y8),
    .great(g8), .less(l8), .equal(e8), .out_valid(v8));

  // ---------------- reference model ----------------
  // Value-level comparison of n-bit operands; {great, less, equal}.
  function automatic logic [2:0] ref_cmp(longint a, longint b, int n);
`ifdef NBITCMP_SIGNED_EN
    if (a >= (longint'(1) << (n - 1))) a = a - (longint'(1) << n);
    if (b >= (longint'(1) << (n - 1))) b = b - (longint'(1) << n);
`endif
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {v,g,l,e}=%b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive4(logic r, logic v, logic [3:0] a, logic [3:0] b);
    @(negedge clk);
    rst = r; in_valid = v; x4 = a; y4 = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] exp_u;
    logic [2:0] exp_s;
  } vec_t;

  vec_t       tbl [16];
  logic [2:0] last_flags;
  logic [2:0] e;
  logic [3:0] exp_v;

  initial begin
    tbl[0]  = '{4'b1101, 4'b1101, 3'b001, 3'b001};
    tbl[1]  = '{4'b0111, 4'b0111, 3'b001, 3'b001};
    tbl[2]  = '{4'b1010, 4'b1010, 3'b001, 3'b001};
    tbl[3]  = '{4'b1110, 4'b1100, 3'b100, 3'b100};
    tbl[4]  = '{4'b1100, 4'b1110, 3'b010, 3'b010};
    tbl[5]  = '{4'b1101, 4'b1111, 3'b010, 3'b010};
    tbl[6]  = '{4'b1111, 4'b1101, 3'b100, 3'b100};
    tbl[7]  = '{4'b1011, 4'b0011, 3'b100, 3'b010};
    tbl[8]  = '{4'b0011, 4'b1011, 3'b010, 3'b100};
    tbl[9]  = '{4'b0101, 4'b0111, 3'b010, 3'b010};
    tbl[10] = '{4'b0111, 4'b0101, 3'b100, 3'b100};
    tbl[11] = '{4'b1000, 4'b0111, 3'b100, 3'b010};
    tbl[12] = '{4'b1111, 4'b1110, 3'b100, 3'b100};
    tbl[13] = '{4'b0000, 4'b1111, 3'b010, 3'b100};
    tbl[14] = '{4'b1111, 4'b0000, 3'b100, 3'b010};
    tbl[15] = '{4'b0000, 4'b0000, 3'b001, 3'b001};

    // Reset state.
    drive4(1'b1, 1'b0, 4'b0, 4'b0);
    tick();
    tick();
    check("reset_state", {v4, g4, l4, e4}, 4'b0000);

    // Table vectors streamed back-to-back, one per cycle.
    for (int i = 0; i < 16; i++) begin
`ifdef NBITCMP_SIGNED_EN
      e = tbl[i].exp_s;
`else
      e = tbl[i].exp_u;
`endif
      drive4(1'b0, 1'b1, tbl[i].x, tbl[i].y);
      tick();
      check($sformatf("tbl[%0d] %b/%b", i, tbl[i].x, tbl[i].y),
            {v4, g4, l4, e4}, {1'b1, e});
      last_flags = e;
    end

    // Drop in_valid: out_valid falls, flags hold.
    drive4(1'b0, 1'b0, 4'b0101, 4'b1010);
    tick();
    check("idle_hold", {v4, g4, l4, e4}, {1'b0, last_flags});
    drive4(1'b0, 1'b0, 4'b0000, 4'b1111);
    tick();
    check("idle_hold2", {v4, g4, l4, e4}, {1'b0, last_flags});

    // Reset wins over in_valid in the same cycle.
    drive4(1'b1, 1'b1, 4'b1110, 4'b0001);
    tick();
    check("rst_over_valid", {v4, g4, l4, e4}, 4'b0000);
    drive4(1'b0, 1'b0, 4'b1110, 4'b0001);
    tick();
    check("post_rst_idle", {v4, g4, l4, e4}, 4'b0000);
    drive4(1'b0, 1'b1, 4'b1110, 4'b0001);
    tick();
    check("post_rst_first", {v4, g4, l4, e4},
          {1'b1, ref_cmp(longint'(4'b1110), longint'(4'b0001), 4)});
    last_flags = ref_cmp(longint'(4'b1110), longint'(4'b0001), 4);

    // Randomized N=4 traffic with gaps, against the model.
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [3:0] a, b;
      v = ($urandom_range(0, 3) != 0);
      a = 4'($urandom);
      b = 4'($urandom);
      if (v) last_flags = ref_cmp(longint'(a), longint'(b), 4);
      exp_q.push_back({v, last_flags});
      drive4(1'b0, v, a, b);
      tick();
      exp_v = exp_q.pop_front();
      check($sformatf("rand4[%0d] %b/%b v=%b", i, a, b, v),
            {v4, g4, l4, e4}, exp_v);
    end

    // Exhaustive sweep: N=8 covers every pair; N=5, N=4 and N=1 every pair
    // many times over, all DUTs in lockstep.
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] c;
      c = 16'(i);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1;
      x8 = c[15:8]; y8 = c[7:0];
      x5 = c[9:5];  y5 = c[4:0];
      x4 = c[7:4];  y4 = c[3:0];
      x1 = c[1:1];  y1 = c[0:0];
      tick();
      check($sformatf("sw8 %h/%h", c[15:8], c[7:0]), {v8, g8, l8, e8},
            {1'b1, ref_cmp(longint'(c[15:8]), longint'(c[7:0]), 8)});
      check($sformatf("sw5 %h/%h", c[9:5], c[4:0]), {v5, g5, l5, e5},
            {1'b1, ref_cmp(longint'(c[9:5]), longint'(c[4:0]), 5)});
      check($sformatf("sw4 %h/%h", c[7:4], c[3:0]), {v4, g4, l4, e4},
            {1'b1, ref_cmp(longint'(c[7:4]), longint'(c[3:0]), 4)});
      check($sformatf("sw1 %b/%b", c[1], c[0]), {v1, g1, l1, e1},
            {1'b1, ref_cmp(longint'(c[1:1]), longint'(c[0:0]), 1)});
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
